axi_rd_responder: RTL and testbench

- AXI read-side slave (responder) for the shared bus.
- Accepts AR requests tagged with the global {master ID, local ID} tag and queues them in order.
- Walks each burst against a single-port synchronous memory and returns R beats with RLAST, RRESP and the echoed tag.
- Sits between the bus interconnect and the backing memory. It is the counterpart of the masters (I$, D$, SP0, SP1) that issue ARs.

---
 rtl/axi_bus_pkg.sv | 62 ++++++
 rtl/axi_ar_fifo.sv | 56 +++++
 rtl/axi_rd_responder.sv | 167 ++++++++++++++++
 tb/tb_axi_rd_responder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bus_pkg.sv
// Shared AXI read-bus definitions: field widths, tag/response/burst types,
// request and beat records, and the per-beat address stepping rule.
package axi_bus_pkg;

   localparam int ARADDR   = 32;
   localparam int ARSIZE   = 3;
   localparam int ARLEN    = 4;
   localparam int ARBURST  = 2;
   localparam int ARID_MID = 4;
   localparam int RDATA    = 64;
   localparam int RRESP    = 2;
   localparam int RID_MID  = 4;

   typedef logic [ARID_MID-1:0] mid_t;

   typedef enum logic [RRESP-1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } rresp_t;

   typedef enum logic [ARBURST-1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10,
      RSVD  = 2'b11
   } burst_t;

   typedef struct packed {
      logic [ARADDR-1:0] addr;
      logic [ARSIZE-1:0] size;
      logic [ARLEN-1:0]  len;
      burst_t            burst;
      mid_t              tag;
   } ar_req_t;

   typedef struct packed {
      logic [RDATA-1:0]   data;
      logic               last;
      rresp_t             resp;
      logic [RID_MID-1:0] tag;
   } r_beat_t;

   // WRAP keeps the bits above the (len+1)<<size boundary and steps the rest.
   function automatic logic [ARADDR-1:0] next_beat_addr(input ar_req_t req);
      logic [ARADDR-1:0] incr;
      logic [ARADDR-1:0] stepped;
      logic [ARADDR-1:0] mask;
      logic [ARADDR-1:0] result;
      incr    = ARADDR'(1) << req.size;
      stepped = req.addr + incr;
      mask    = ((ARADDR'(req.len) + ARADDR'(1)) << req.size) - ARADDR'(1);
      case (req.burst)
         FIXED:   result = req.addr;
         WRAP:    result = (req.addr & ~mask) | (stepped & mask);
         default: result = stepped;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/axi_ar_fifo.sv
// Parameterised synchronous FIFO with full/empty flags; push and pop in the
// same cycle are both honoured. Head entry is presented combinationally.
module axi_ar_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];

   // NOTE: storage has no reset; only the pointers and count define validity.
   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI read responder: queues AR requests in order, walks each burst against a
// single-port synchronous memory and returns tagged R beats through a 2-deep buffer.
module axi_rd_responder
   import axi_bus_pkg::*;
#(
   parameter int          AR_DEPTH  = 4,
   parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
   parameter logic [31:0] MEM_BYTES = 32'h0001_0000
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ARADDR-1:0]   araddr,
   input  logic [ARSIZE-1:0]   arsize,
   input  logic [ARLEN-1:0]    arlen,
   input  logic [ARBURST-1:0]  arburst,
   input  logic [ARID_MID-1:0] armid_id,
   output logic                rvalid,
   input  logic                rready,
   output logic [RDATA-1:0]    rdata,
   output logic                rlast,
   output logic [RRESP-1:0]    rresp,
   output logic [RID_MID-1:0]  rmid_id,
   output logic                mem_ren,
   output logic [ARADDR-1:0]   mem_addr,
   input  logic [RDATA-1:0]    mem_rdata
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             r_live;
   ar_req_t          r_cur;
   logic [ARLEN-1:0] r_beat;

   ar_req_t          w_ar_in;
   ar_req_t          w_ar_head;
   logic             w_ar_push;
   logic             w_ar_pop;
   logic             w_ar_full;
   logic             w_ar_empty;

   logic             w_issue;
   logic             w_last_issue;
   logic             w_credit;
   rresp_t           w_resp;
   logic [ARADDR-1:0] w_offset;

   logic             r_if_valid;
   logic             r_if_last;
   rresp_t           r_if_resp;
   mid_t             r_if_tag;

   r_beat_t          w_rb_in;
   r_beat_t          w_rb_head;
   logic             w_rb_pop;
   logic             w_rb_full;
   logic             w_rb_empty;
   logic [1:0]       w_rb_occ;

   // r_live holds arready low until the first edge after reset release.
   assign arready   = r_live && !w_ar_full;
   assign w_ar_push = arvalid && arready;
   assign w_ar_in   = '{addr: araddr, size: arsize, len: arlen,
                        burst: burst_t'(arburst), tag: armid_id};

   axi_ar_fifo #(.WIDTH($bits(ar_req_t)), .DEPTH(AR_DEPTH)) u_ar_fifo (
      .CLK     (CLK),
      .nRST    (nRST),
      .i_push  (w_ar_push),
      .i_data  (w_ar_in),
      .i_pop   (w_ar_pop),
      .o_data  (w_ar_head),
      .o_full  (w_ar_full),
      .o_empty (w_ar_empty)
   );

   // Credit: buffered beats plus the beat in flight, net of this cycle's pop.
   assign w_rb_occ = w_rb_full ? 2'd2 : (w_rb_empty ? 2'd0 : 2'd1);
   assign w_rb_pop = !w_rb_empty && rready;
   assign w_credit = ({1'b0, w_rb_occ} + {2'b00, r_if_valid} - {2'b00, w_rb_pop}) < 3'd2;

   assign w_offset = r_cur.addr - MEM_BASE;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_resp = RESP_OKAY;
      if (w_offset >= MEM_BYTES)                         w_resp = RESP_DECERR;
      else if (r_cur.size > 3'd3 || r_cur.burst == RSVD) w_resp = RESP_SLVERR;
   end

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_last_issue = 1'b0;
      w_ar_pop     = 1'b0;
      case (r_state)
         IDLE: begin
            w_ar_pop = !w_ar_empty;
            if (!w_ar_empty) w_state_next = BURST;
         end
         BURST: begin
            w_issue      = w_credit;
            w_last_issue = w_credit && (r_beat == r_cur.len);
            if (w_last_issue) begin
               w_ar_pop     = !w_ar_empty;
               w_state_next = w_ar_empty ? IDLE : BURST;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign mem_ren  = w_issue && (w_resp == RESP_OKAY);
   assign mem_addr = mem_ren ? (w_offset & ~32'h7) : '0;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state    <= IDLE;
         r_live     <= 1'b0;
         r_cur      <= '0;
         r_beat     <= '0;
         r_if_valid <= 1'b0;
         r_if_last  <= 1'b0;
         r_if_resp  <= RESP_OKAY;
         r_if_tag   <= '0;
      end else begin
         r_state    <= w_state_next;
         r_live     <= 1'b1;
         if (w_ar_pop) begin
            r_cur  <= w_ar_head;
            r_beat <= '0;
         end else if (w_issue) begin
            r_cur.addr <= next_beat_addr(r_cur);
            r_beat     <= r_beat + ARLEN'(1);
         end
         r_if_valid <= w_issue;
         r_if_last  <= w_last_issue;
         r_if_resp  <= w_resp;
         r_if_tag   <= r_cur.tag;
      end
   end

   // Error beats carry zero data; memory output is ignored for them.
   assign w_rb_in = '{data: (r_if_resp == RESP_OKAY) ? mem_rdata : '0,
                      last: r_if_last, resp: r_if_resp, tag: r_if_tag};

   axi_ar_fifo #(.WIDTH($bits(r_beat_t)), .DEPTH(2)) u_r_buf (
      .CLK     (CLK),
      .nRST    (nRST),
      .i_push  (r_if_valid),
      .i_data  (w_rb_in),
      .i_pop   (w_rb_pop),
      .o_data  (w_rb_head),
      .o_full  (w_rb_full),
      .o_empty (w_rb_empty)
   );

   assign rvalid  = !w_rb_empty;
   assign rdata   = rvalid ? w_rb_head.data : '0;
   assign rlast   = rvalid && w_rb_head.last;
   assign rresp   = rvalid ? w_rb_head.resp : RESP_OKAY;
   assign rmid_id = rvalid ? w_rb_head.tag : '0;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Randomised self-checking bench for axi_rd_responder against a burst-level
// reference model of expected R beats and memory reads.
module tb_axi_rd_responder;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam logic [31:0] BYTES = 32'h0001_0000;
   localparam int B_FIXED = 0, B_INCR = 1, B_WRAP = 2, B_RSVD = 3;

   typedef logic [71:0] val_t;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [1:0]  resp;
      logic [3:0]  tag;
   } exp_beat_t;

   typedef struct {
      logic [31:0] addr;
      int          size;
      int          len;
      int          burst;
      logic [3:0]  tag;
   } ar_t;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic [3:0]  arlen;
   logic [1:0]  arburst;
   logic [3:0]  armid_id;
   logic        rvalid, rready, rlast;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic [3:0]  rmid_id;
   logic        mem_ren;
   logic [31:0] mem_addr;
   logic [63:0] mem_rdata = 64'h0;

   int n_checks = 0;
   int n_pass   = 0;
   int rr_mode  = 1;

   exp_beat_t   exp_q[$];
   logic [31:0] exp_mem_q[$];

   axi_rd_responder #(.AR_DEPTH(4), .MEM_BASE(BASE), .MEM_BYTES(BYTES)) dut (
      .CLK(CLK), .nRST(nRST),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
      .arlen(arlen), .arburst(arburst), .armid_id(armid_id),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
      .rresp(rresp), .rmid_id(rmid_id),
      .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input val_t got, input val_t exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [63:0] pattern(input logic [31:0] off);
      return {off ^ 32'hDEAD_BEEF, ~off};
   endfunction

   // Synchronous memory: data one cycle after a read strobe, junk otherwise.
   always @(posedge CLK) begin
      if (mem_ren) mem_rdata <= pattern(mem_addr);
      else         mem_rdata <= {$urandom, $urandom};
   end

   initial begin
      rready = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         case (rr_mode)
            0:       rready = 1'b0;
            1:       rready = 1'b1;
            2:       rready = ~rready;
            default: rready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Reference model: expand one AR into its beats and memory reads.
   task automatic model_push(input ar_t ar);
      logic [31:0] a, off, incr, bound, base;
      exp_beat_t   b;
      a    = ar.addr;
      incr = 32'd1 << ar.size;
      for (int i = 0; i <= ar.len; i++) begin
         off    = a - BASE;
         b.tag  = ar.tag;
         b.last = (i == ar.len);
         if (off >= BYTES)                        b.resp = 2'b11;
         else if (ar.size > 3 || ar.burst == B_RSVD) b.resp = 2'b10;
         else                                     b.resp = 2'b00;
         b.data = (b.resp == 2'b00) ? pattern(off & ~32'h7) : 64'h0;
         if (b.resp == 2'b00) exp_mem_q.push_back(off & ~32'h7);
         exp_q.push_back(b);
         if (ar.burst == B_WRAP) begin
            bound = 32'(ar.len + 1) * incr;
            base  = a - (a % bound);
            a     = base + ((a + incr) % bound);
         end else if (ar.burst != B_FIXED) begin
            a = a + incr;
         end
      end
   endtask

   // Monitor: memory reads, R handshakes and payload stability under stall.
   logic        hold_prev = 1'b0;
   logic [70:0] prev_pl;
   always @(negedge CLK) begin
      exp_beat_t b;
      if (!nRST) begin
         hold_prev = 1'b0;
      end else begin
         if (mem_ren) begin
            if (exp_mem_q.size() == 0) check("mem_ren_unexpected", val_t'(1), val_t'(0));
            else check("mem_addr", val_t'(mem_addr), val_t'(exp_mem_q.pop_front()));
         end
         if (hold_prev) begin
            check("r_hold_valid", val_t'(rvalid), val_t'(1));
            check("r_hold_payload", val_t'({rdata, rlast, rresp, rmid_id}), val_t'(prev_pl));
         end
         if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
               check("r_unexpected", val_t'(1), val_t'(0));
            end else begin
               b = exp_q.pop_front();
               check("rdata", val_t'(rdata), val_t'(b.data));
               check("rlast", val_t'(rlast), val_t'(b.last));
               check("rresp", val_t'(rresp), val_t'(b.resp));
               check("rmid_id", val_t'(rmid_id), val_t'(b.tag));
            end
         end
         hold_prev = rvalid && !rready;
         prev_pl   = {rdata, rlast, rresp, rmid_id};
      end
   end

   function automatic ar_t mk(input logic [31:0] a, input int s, input int l,
                              input int bt, input logic [3:0] t);
      ar_t ar;
      ar.addr = a; ar.size = s; ar.len = l; ar.burst = bt; ar.tag = t;
      return ar;
   endfunction

   task automatic drive_ar(input ar_t ar);
      arvalid  = 1'b1;
      araddr   = ar.addr;
      arsize   = 3'(ar.size);
      arlen    = 4'(ar.len);
      arburst  = 2'(ar.burst);
      armid_id = ar.tag;
   endtask

   task automatic wait_accept(input ar_t ar);
      bit done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge CLK);
         if (arready) begin
            @(posedge CLK);
            model_push(ar);
            #1;
            arvalid = 1'b0;
            done    = 1'b1;
         end
      end
      if (!done) begin
         check("ar_accept_timeout", val_t'(0), val_t'(1));
         @(posedge CLK);
         #1;
         arvalid = 1'b0;
      end
   endtask

   task automatic send_ar(input ar_t ar);
      drive_ar(ar);
      wait_accept(ar);
   endtask

   task automatic drain();
      int k = 0;
      while ((exp_q.size() != 0 || exp_mem_q.size() != 0) && k < 1000) begin
         @(posedge CLK);
         k++;
      end
      check("drain_in_time", val_t'(k < 1000), val_t'(1));
      repeat (3) @(posedge CLK);
      #1;
      check("idle_rvalid", val_t'(rvalid), val_t'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_arready"}, val_t'(arready), val_t'(0));
      check({tag, "_rvalid"}, val_t'(rvalid), val_t'(0));
      check({tag, "_rlast"}, val_t'(rlast), val_t'(0));
      check({tag, "_rresp"}, val_t'(rresp), val_t'(0));
      check({tag, "_rdata"}, val_t'(rdata), val_t'(0));
      check({tag, "_rmid_id"}, val_t'(rmid_id), val_t'(0));
      check({tag, "_mem_ren"}, val_t'(mem_ren), val_t'(0));
      check({tag, "_mem_addr"}, val_t'(mem_addr), val_t'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n, cnt, gap;
      ar_t ar;
      arvalid = 1'b0; araddr = '0; arsize = '0; arlen = '0; arburst = '0; armid_id = '0;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outputs("reset");
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      // Single beat with latency measurement.
      rr_mode = 1;
      send_ar(mk(32'h40, 3, 0, B_INCR, 4'h9));
      n = 0;
      while (n < 20) begin
         @(negedge CLK);
         if (rvalid) break;
         n++;
         @(posedge CLK);
      end
      check("first_rvalid_latency", val_t'(n), val_t'(3));
      drain();

      // INCR under toggling rready, then WRAP.
      rr_mode = 2;
      send_ar(mk(32'h100, 3, 3, B_INCR, 4'h2));
      drain();
      rr_mode = 1;
      send_ar(mk(32'h18, 3, 3, B_WRAP, 4'h5));
      drain();

      // Backpressure: one burst in the engine, four queued, sixth refused.
      rr_mode = 0;
      for (int i = 0; i < 5; i++) send_ar(mk(32'h400 + 32'(i) * 32'h40, 3, 3, B_INCR, 4'(i)));
      ar = mk(32'h800, 3, 3, B_INCR, 4'h5);
      drive_ar(ar);
      repeat (3) begin
         @(negedge CLK);
         check("ar_full_refused", val_t'(arready), val_t'(0));
      end
      rr_mode = 1;
      wait_accept(ar);
      drain();

      // Error beats.
      send_ar(mk(BASE + BYTES, 3, 1, B_INCR, 4'hA));
      send_ar(mk(32'h80, 4, 0, B_INCR, 4'hB));
      send_ar(mk(32'h90, 3, 2, B_RSVD, 4'hC));
      drain();

      // Randomised traffic with random backpressure.
      rr_mode = 3;
      for (int i = 0; i < 60; i++) begin
         ar.tag   = 4'($urandom_range(0, 15));
         ar.burst = $urandom_range(0, 3);
         ar.size  = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
         if (ar.burst == B_WRAP) ar.len = (2 << $urandom_range(0, 3)) - 1;
         else                    ar.len = $urandom_range(0, 15);
         if ($urandom_range(0, 3) == 0) ar.addr = BYTES - 32'($urandom_range(0, 64));
         else                           ar.addr = 32'($urandom_range(0, 32'hFFFF));
         if (ar.size <= 3) ar.addr = ar.addr & ~((32'd1 << ar.size) - 32'd1);
         send_ar(ar);
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            repeat (gap) @(posedge CLK);
            #1;
         end
      end
      drain();

      // Reset during beat 2 of an 8-beat burst.
      rr_mode = 1;
      send_ar(mk(32'h200, 3, 7, B_INCR, 4'h7));
      cnt = 0;
      for (int k = 0; k < 100 && cnt < 2; k++) begin
         @(negedge CLK);
         if (mem_ren) cnt++;
      end
      check("rst_burst_started", val_t'(cnt), val_t'(2));
      #1;
      nRST = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      exp_mem_q.delete();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check("arready_after_release", val_t'(arready), val_t'(1));
      repeat (20) @(posedge CLK);
      #1;
      check("no_stale_rvalid", val_t'(rvalid), val_t'(0));
      send_ar(mk(32'h48, 3, 0, B_INCR, 4'h3));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
